// File: rtl/ifu_pfq.sv
// ifu_pfq: instruction prefetch queue between a synchronous instruction SRAM and the decoder.
//
// Issues one SRAM read per cycle while queue credit allows (occupancy plus the read in
// flight must stay below DEPTH), buffers responses as {pc, ins} in a DEPTH-entry FIFO and
// hands the oldest entry to the consumer. A branch restarts fetch at br_adr. A flush
// replays from the oldest instruction not yet handed off.
//
// Optional feature: define IFU_PFQ_BYPASS_EN to present a response directly on the
// ifu_* outputs when the FIFO is empty. It is only pushed if it is not taken that cycle.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   flush           discard queued and in-flight instructions, replay from cpc
//   stall           consumer stall; head instruction is not taken while high
//   branch, br_adr  redirect fetch to {br_adr[31:2], 2'b00}; priority over flush
//   ifu_vld/pc/ins  head instruction to the consumer (pc/ins are 0 when not valid)
//   ins_a, ins_e    SRAM word address and read enable
//   ins             SRAM read data, valid the cycle after ins_e
module ifu_pfq #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          stall,
  input  logic          branch,
  input  logic [31:0]   br_adr,
  output logic          ifu_vld,
  output logic [31:0]   ifu_pc,
  output logic [31:0]   ifu_ins,
  output logic [AW-1:0] ins_a,
  output logic          ins_e,
  input  logic [31:0]   ins
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   cpc_q, cpc_d;
  logic [31:0]   ipc_q, ipc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] ins_mem [DEPTH];

  logic          redirect;
  logic          rsp_ok;
  logic          fifo_nonempty;
  logic          byp;
  logic          take;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic [31:0]   head_pc;
  logic [31:0]   head_ins;
  logic [31:0]   br_tgt;
  logic [1:0]    unused_br_lsb;

  assign unused_br_lsb = br_adr[1:0];
  assign br_tgt        = {br_adr[31:2], 2'b00};
  assign redirect      = branch | flush;
  assign fifo_nonempty = (count_q != '0);

  // A response is usable only if it was not cancelled earlier and no redirect is
  // happening in the response cycle itself.
  assign rsp_ok = inflight_q & ~drop_q & ~redirect;

`ifdef IFU_PFQ_BYPASS_EN
  assign byp = rsp_ok & ~fifo_nonempty;
`else
  assign byp = 1'b0;
`endif

  // Credit check takes no account of a same-cycle pop.
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign ins_e = rstn & ~redirect & (occ < (CW + 1)'(DEPTH));
  assign ins_a = fpc_q[AW+1:2];

  assign head_pc  = fifo_nonempty ? pc_mem[rd_ptr_q]  : ipc_q;
  assign head_ins = fifo_nonempty ? ins_mem[rd_ptr_q] : ins;

  assign ifu_vld = rstn & ~redirect & (fifo_nonempty | byp);
  assign ifu_pc  = ifu_vld ? head_pc  : 32'h0;
  assign ifu_ins = ifu_vld ? head_ins : 32'h0;

  assign take = ifu_vld & ~stall;
  assign pop  = take & fifo_nonempty;
  assign push = rsp_ok & ~(byp & take);

  always_comb begin
    fpc_d      = fpc_q;
    cpc_d      = cpc_q;
    ipc_d      = ipc_q;
    inflight_d = ins_e;
    drop_d     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (ins_e) begin
      ipc_d = fpc_q;
      fpc_d = fpc_q + 32'd4;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (take) begin
      cpc_d = head_pc + 32'd4;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // The response landing this cycle is already rejected by rsp_ok; drop marks that
      // any read outstanding across the redirect is stale.
      drop_d   = inflight_q;
      if (branch) begin
        fpc_d = br_tgt;
        cpc_d = br_tgt;
      end else begin
        fpc_d = cpc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc_q      <= RESET_PC;
      cpc_q      <= RESET_PC;
      ipc_q      <= 32'h0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      cpc_q      <= cpc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= ipc_q;
      ins_mem[wr_ptr_q] <= ins;
    end
  end

endmodule

// File: tb/tb_ifu_pfq.sv
module tb_ifu_pfq;

  localparam int unsigned AW       = 16;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFU_PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          stall;
  logic          branch;
  logic [31:0]   br_adr;
  logic          ifu_vld;
  logic [31:0]   ifu_pc;
  logic [31:0]   ifu_ins;
  logic [AW-1:0] ins_a;
  logic          ins_e;
  logic [31:0]   ins;

  ifu_pfq #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .stall   (stall),
    .branch  (branch),
    .br_adr  (br_adr),
    .ifu_vld (ifu_vld),
    .ifu_pc  (ifu_pc),
    .ifu_ins (ifu_ins),
    .ins_a   (ins_a),
    .ins_e   (ins_e),
    .ins     (ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-tagged instruction word.
  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // SRAM: data for an enabled read appears next cycle; otherwise junk.
  always @(posedge clk) begin
    if (ins_e) ins <= data_of(ins_a);
    else       ins <= $urandom();
  end

  int errors = 0;
  int checks = 0;

  // Reference model: queue of buffered PCs, one outstanding read, fetch and consume PCs.
  logic [31:0] mq[$];
  bit          m_inf;
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;
  logic [31:0] m_cpc;

  logic          s_vld;
  logic          s_ins_e;
  logic [31:0]   s_pc;
  logic [31:0]   s_ins;
  logic [AW-1:0] s_ins_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model, return
  // just after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    int          n;
    bit          redir, rsp, byp, take;
    bit          e_vld, e_ins_e;
    logic [31:0] e_pc, e_ins;
    @(negedge clk);
    s_vld   = ifu_vld;
    s_ins_e = ins_e;
    s_pc    = ifu_pc;
    s_ins   = ifu_ins;
    s_ins_a = ins_a;
    if (!rstn) begin
      mq.delete();
      m_inf = 1'b0;
      m_ipc = 32'h0;
      m_fpc = RESET_PC;
      m_cpc = RESET_PC;
      chk("rst_vld", 32'(s_vld), 32'h0);
      chk("rst_ins_e", 32'(s_ins_e), 32'h0);
      chk("rst_pc", s_pc, 32'h0);
      chk("rst_ins", s_ins, 32'h0);
    end else begin
      n       = mq.size();
      redir   = branch | flush;
      rsp     = m_inf & ~redir;
      byp     = BYP && rsp && (n == 0);
      e_vld   = !redir && (n > 0 || byp);
      e_pc    = e_vld ? ((n > 0) ? mq[0] : m_ipc) : 32'h0;
      e_ins   = e_vld ? data_of(e_pc[AW+1:2]) : 32'h0;
      e_ins_e = !redir && ((n + int'(m_inf)) < DEPTH);
      chk("ins_e", 32'(s_ins_e), 32'(e_ins_e));
      if (e_ins_e) chk("ins_a", 32'(s_ins_a), 32'(m_fpc[AW+1:2]));
      chk("vld", 32'(s_vld), 32'(e_vld));
      chk("pc", s_pc, e_pc);
      chk("ins", s_ins, e_ins);
      if (e_vld) chk("order", s_pc, m_cpc);
      take = e_vld && !stall;
      if (take) begin
        if (n > 0) void'(mq.pop_front());
        m_cpc = e_pc + 32'd4;
      end
      if (rsp && !(byp && take)) mq.push_back(m_ipc);
      if (e_ins_e) begin
        m_inf = 1'b1;
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end else begin
        m_inf = 1'b0;
      end
      if (branch) begin
        mq.delete();
        m_fpc = {br_adr[31:2], 2'b00};
        m_cpc = m_fpc;
      end else if (flush) begin
        mq.delete();
        m_fpc = m_cpc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit st);
    rstn   = 1'b0;
    stall  = st;
    branch = 1'b0;
    flush  = 1'b0;
    br_adr = 32'h0;
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  // Run until ifu_vld is seen (bounded); reports whether it was seen.
  task automatic wait_vld(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (s_vld) seen = 1'b1;
    end
  endtask

  initial begin
    int          first;
    int          issues;
    int          resume;
    int          got;
    bit          seen;
    logic [31:0] pcs [3];

    rstn   = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    branch = 1'b0;
    br_adr = 32'h0;
    ins    = 32'h0;

    // Streaming from reset: one fetch and (after the pipeline fills) one handoff per cycle.
    do_reset(1'b0);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("a_ins_a", 32'(s_ins_a), 32'(k));
      if (s_vld) begin
        if (first < 0) begin
          first = k;
          chk("a_first_pc", s_pc, 32'h0);
        end else begin
          chk("a_next_pc", s_pc, 32'(4 * (k - first)));
        end
      end
    end
    chk("a_first_cycle", 32'(first), BYP ? 32'd1 : 32'd2);

    // Stall from reset: queue fills to DEPTH, then drains in order.
    do_reset(1'b1);
    issues = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (s_ins_e) issues++;
    end
    chk("b_issues", 32'(issues), 32'(DEPTH));
    chk("b_idle_ins_e", 32'(s_ins_e), 32'h0);
    stall  = 1'b0;
    resume = -1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("b_drain_pc", s_pc, 32'(4 * k));
      if (s_ins_e && resume < 0) resume = int'(s_ins_a);
    end
    chk("b_resume_a", 32'(resume), 32'd4);

    // Branch with two queued and one in flight.
    do_reset(1'b1);
    repeat (3) cycle();
    branch = 1'b1;
    br_adr = 32'h0000_0103;
    stall  = 1'b0;
    cycle();
    chk("c_vld_br", 32'(s_vld), 32'h0);
    branch = 1'b0;
    br_adr = $urandom();
    cycle();
    chk("c_vld_after", 32'(s_vld), 32'h0);
    chk("c_ins_a", 32'(s_ins_a), 32'h40);
    wait_vld(6, seen);
    chk("c_vld_seen", 32'(seen), 32'h1);
    chk("c_pc", s_pc, 32'h100);

    // Flush after 0x0 and 0x4 were consumed: replay from 0x8.
    do_reset(1'b1);
    repeat (6) cycle();
    stall = 1'b0;
    cycle();
    chk("d_pc0", s_pc, 32'h0);
    cycle();
    chk("d_pc4", s_pc, 32'h4);
    flush = 1'b1;
    cycle();
    chk("d_vld_fl", 32'(s_vld), 32'h0);
    flush = 1'b0;
    cycle();
    chk("d_ins_a", 32'(s_ins_a), 32'h2);
    chk("d_vld_after", 32'(s_vld), 32'h0);
    wait_vld(6, seen);
    chk("d_vld_seen", 32'(seen), 32'h1);
    chk("d_pc8", s_pc, 32'h8);

    // Reset in the middle of a busy queue.
    do_reset(1'b1);
    repeat (4) cycle();
    rstn = 1'b0;
    cycle();
    chk("e_vld", 32'(s_vld), 32'h0);
    chk("e_ins_e", 32'(s_ins_e), 32'h0);
    cycle();
    rstn  = 1'b1;
    stall = 1'b0;
    cycle();
    chk("e_ins_a", 32'(s_ins_a), 32'(RESET_PC[AW+1:2]));
    wait_vld(4, seen);
    chk("e_vld_seen", 32'(seen), 32'h1);
    chk("e_pc", s_pc, RESET_PC);
    chk("e_ins", s_ins, data_of(RESET_PC[AW+1:2]));

    // Branch to the top of the address space wraps to 0.
    do_reset(1'b0);
    repeat (3) cycle();
    branch = 1'b1;
    br_adr = 32'hFFFF_FFFC;
    cycle();
    branch = 1'b0;
    got    = 0;
    for (int i = 0; i < 12 && got < 3; i++) begin
      cycle();
      if (s_vld) begin
        pcs[got] = s_pc;
        got++;
      end
    end
    chk("f_count", 32'(got), 32'd3);
    chk("f_pc0", pcs[0], 32'hFFFF_FFFC);
    chk("f_pc1", pcs[1], 32'h0);
    chk("f_pc2", pcs[2], 32'h4);

    // Random traffic against the model.
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      stall  = ($urandom_range(3) == 0);
      branch = ($urandom_range(19) == 0);
      flush  = ($urandom_range(19) == 0);
      br_adr = $urandom();
      rstn   = ($urandom_range(99) != 0);
      cycle();
    end
    rstn   = 1'b1;
    branch = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
